// File: rtl/axilite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns cmd/rsp requests into AW+W->B or AR->R transactions.
// Define AXIL_MCTRL_TIMEOUT_EN to build the watchdog that ends a stuck transaction after TIMEOUT_CYCLES.
module axilite_master_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;

  assign cmd_ready = (state == IDLE) && !areset;

  // A channel counts as done once its valid has dropped or its ready is sampled this edge.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

`ifdef AXIL_MCTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt;
  logic             rsp_timeout_q;
  logic             completing;
  logic             wd_expired;

  always_comb begin
    completing = ((state == WR_RESP) && m_axi_bvalid && m_axi_bready) ||
                 ((state == RD_RESP) && m_axi_rvalid && m_axi_rready);
    wd_expired = (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) &&
                 (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !completing;
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_araddr  <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
`ifdef AXIL_MCTRL_TIMEOUT_EN
      wd_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid && m_axi_bready) begin
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_axi_rvalid && m_axi_rready) begin
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef AXIL_MCTRL_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_MCTRL_TIMEOUT_EN
      if (state == IDLE) begin
        wd_cnt <= '0;
      end else if (state != RSP) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      // Watchdog overrides the normal sequencing; readies drop so late beats are never taken.
      if (wd_expired) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        rsp_timeout_q <= 1'b1;
        rsp_valid     <= 1'b1;
        state         <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axilite_master_ctrl.sv
// Self-checking bench for axilite_master_ctrl: random-latency AXI-Lite slave plus a word-array reference model.
// Timeout checks run only when AXIL_MCTRL_TIMEOUT_EN is defined (watchdog limit 16).
module tb_axilite_master_ctrl;

  localparam int TB_TIMEOUT = 16;
  localparam int MEM_WORDS  = 64;

  logic        aclk;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  int checks;
  int errors;

  logic stall_aw;
  logic hold_b;
  logic force_b;

  logic [31:0] ref_mem [0:MEM_WORDS-1] = '{default: 32'h0};
  logic [31:0] slave_mem [0:MEM_WORDS-1] = '{default: 32'h0};

  axilite_master_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Slave: random readies, DECERR outside the word array, B/R issued a cycle after the request lands.
  logic        aw_got, w_got, ar_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axi_awready <= 1'b0;
      m_axi_wready  <= 1'b0;
      m_axi_arready <= 1'b0;
      m_axi_bvalid  <= 1'b0;
      m_axi_bresp   <= 2'b00;
      m_axi_rvalid  <= 1'b0;
      m_axi_rdata   <= 32'h0;
      m_axi_rresp   <= 2'b00;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      ar_got        <= 1'b0;
      s_awaddr      <= 32'h0;
      s_wdata       <= 32'h0;
      s_araddr      <= 32'h0;
    end else begin
      m_axi_awready <= stall_aw ? 1'b0 : ($urandom_range(0, 3) != 0);
      m_axi_wready  <= ($urandom_range(0, 3) != 0);
      m_axi_arready <= ($urandom_range(0, 3) != 0);
      if (m_axi_awvalid && m_axi_awready && !aw_got) begin
        aw_got   <= 1'b1;
        s_awaddr <= m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready && !w_got) begin
        w_got   <= 1'b1;
        s_wdata <= m_axi_wdata;
      end
      if (aw_got && w_got && !m_axi_bvalid && !hold_b) begin
        if (s_awaddr < MEM_WORDS) begin
          slave_mem[s_awaddr[5:0]] <= s_wdata;
          m_axi_bresp <= 2'b00;
        end else begin
          m_axi_bresp <= 2'b11;
        end
        m_axi_bvalid <= 1'b1;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
      end else if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
      end
      if (force_b) m_axi_bvalid <= 1'b1;
      if (m_axi_arvalid && m_axi_arready && !ar_got && !m_axi_rvalid) begin
        ar_got   <= 1'b1;
        s_araddr <= m_axi_araddr;
      end
      if (ar_got && !m_axi_rvalid) begin
        m_axi_rdata  <= (s_araddr < MEM_WORDS) ? slave_mem[s_araddr[5:0]] : 32'h0;
        m_axi_rresp  <= (s_araddr < MEM_WORDS) ? 2'b00 : 2'b11;
        m_axi_rvalid <= 1'b1;
        ar_got       <= 1'b0;
      end else if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command and checks the AXI request appears exactly one cycle after acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int n;
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    checkOutput("valid_before_accept", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'd0);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    if (wr) begin
      checkOutput("aw_w_valid_rise", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'b110);
      checkOutput("awaddr", 64'(m_axi_awaddr), 64'(addr));
      checkOutput("wdata", 64'(m_axi_wdata), 64'(data));
    end else begin
      checkOutput("arvalid_rise", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'b001);
      checkOutput("araddr", 64'(m_axi_araddr), 64'(addr));
    end
    checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic waitRsp();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("rsp_valid_wait", 64'(rsp_valid), 64'd1);
  endtask

  task automatic checkRsp(input logic [31:0] exp_data, input logic [1:0] exp_resp, input logic exp_tout);
    checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_data));
    checkOutput("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
    checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(exp_tout));
  endtask

  task automatic releaseRsp();
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", 64'(rsp_valid), 64'd0);
    checkOutput("rsp_timeout_cleared", 64'(rsp_timeout), 64'd0);
    checkOutput("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  function automatic logic [31:0] expData(input logic wr, input logic [31:0] addr);
    if (wr || addr >= MEM_WORDS) return 32'h0;
    return ref_mem[addr[5:0]];
  endfunction

  function automatic logic [1:0] expResp(input logic [31:0] addr);
    return (addr < MEM_WORDS) ? 2'b00 : 2'b11;
  endfunction

  task automatic doTxn(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    exp_d = expData(wr, addr);
    exp_r = expResp(addr);
    applyStimulus(wr, addr, data);
    waitRsp();
    checkRsp(exp_d, exp_r, 1'b0);
    releaseRsp();
    if (wr && addr < MEM_WORDS) ref_mem[addr[5:0]] = data;
  endtask

  initial begin
    logic [31:0] exp_d;
    int          n;
    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    stall_aw  = 1'b0;
    hold_b    = 1'b0;
    force_b   = 1'b0;
    checks    = 0;
    errors    = 0;

    repeat (2) @(negedge aclk);
    checkOutput("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, m_axi_awvalid,
                                   m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    checkOutput("reset_rdata_awaddr", {rsp_rdata, m_axi_awaddr}, 64'd0);
    checkOutput("reset_wdata_araddr", {m_axi_wdata, m_axi_araddr}, 64'd0);
    areset = 1'b0;
    #1;
    checkOutput("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    doTxn(1'b1, 32'h5, 32'hDEADBEEF);
    doTxn(1'b0, 32'h5, 32'h0);
    doTxn(1'b1, 32'd200, 32'h13572468);
    doTxn(1'b0, 32'd200, 32'h0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge aclk);
      doTxn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 79)), $urandom);
    end

    // Stalled consumer: response must stay frozen while a new command waits.
    applyStimulus(1'b0, 32'h5, 32'h0);
    waitRsp();
    exp_d = expData(1'b0, 32'h5);
    checkRsp(exp_d, 2'b00, 1'b0);
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h6;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
      checkOutput("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge aclk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("hold_release_valid", 64'(rsp_valid), 64'd0);
    checkOutput("hold_release_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("pending_accept_arvalid", 64'(m_axi_arvalid), 64'd1);
    checkOutput("pending_accept_araddr", 64'(m_axi_araddr), 64'h6);
    waitRsp();
    checkRsp(expData(1'b0, 32'h6), 2'b00, 1'b0);
    releaseRsp();

    // Asynchronous reset while waiting on B; the aborted write must leave no trace.
    hold_b = 1'b1;
    applyStimulus(1'b1, 32'h5, 32'hA5A5A5A5);
    n = 0;
    while (m_axi_bready !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("wr_resp_reached", 64'(m_axi_bready), 64'd1);
    #2;
    areset = 1'b1;
    #1;
    checkOutput("async_reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_timeout, rsp_resp, m_axi_awvalid,
                                         m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    checkOutput("async_reset_rdata_awaddr", {rsp_rdata, m_axi_awaddr}, 64'd0);
    checkOutput("async_reset_wdata_araddr", {m_axi_wdata, m_axi_araddr}, 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    hold_b = 1'b0;
    #1;
    checkOutput("cmd_ready_after_abort", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checkOutput("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    doTxn(1'b0, 32'h5, 32'h0);

`ifdef AXIL_MCTRL_TIMEOUT_EN
    // AW never accepted: watchdog fires after TB_TIMEOUT busy cycles; a later B beat is ignored.
    stall_aw = 1'b1;
    applyStimulus(1'b1, 32'h7, 32'hCAFEF00D);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("timeout_latency", 64'(n), 64'(TB_TIMEOUT));
    checkOutput("timeout_valids_dropped", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    checkRsp(32'h0, 2'b10, 1'b1);
    force_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checkOutput("late_b_ignored", 64'(m_axi_bready), 64'd0);
    end
    releaseRsp();
    @(negedge aclk);
    checkOutput("late_b_ignored_idle", 64'(m_axi_bready), 64'd0);
    force_b  = 1'b0;
    stall_aw = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
